// File: rtl/fp32_mul_round_normalize.sv
// Final FP32 multiplier stage: resolves the redundant sum/carry product, normalizes,
// rounds to nearest-even and packs the result. Two-entry valid/ready pipeline.
module fp32_mul_round_normalize #(
  parameter int PROD_W = 52,
  parameter int EXP_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_sum,
  input  logic [PROD_W-1:0] in_carry,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic              in_zero,
  input  logic              in_inf,
  input  logic              in_nan,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic              out_overflow,
  output logic              out_underflow
);

  localparam int MEAN_W = 48;
  localparam int E_W    = EXP_W + 2;
  localparam logic signed [E_W-1:0] E_MAX  = E_W'(255);
  localparam logic signed [E_W-1:0] E_ZERO = '0;

  logic [PROD_W-1:0] prod_full;
  logic              unused_prod_hi;

  logic              s1_valid_reg;
  logic [MEAN_W-1:0] s1_prod_reg;
  logic              s1_sign_reg;
  logic [EXP_W-1:0]  s1_exp_reg;
  logic              s1_zero_reg;
  logic              s1_inf_reg;
  logic              s1_nan_reg;

  logic              out_valid_reg;
  logic [31:0]       out_result_reg;
  logic              out_overflow_reg;
  logic              out_underflow_reg;

  logic              s2_accept;
  logic              norm_hi;
  logic [22:0]       man_pre;
  logic              guard_bit;
  logic              sticky_bit;
  logic              round_up;
  logic [23:0]       man_sum;
  logic signed [E_W-1:0] e_rnd;
  logic [31:0]       result_next;
  logic              overflow_next;
  logic              underflow_next;

  // Carry is pre-aligned upstream, so a plain add resolves the product; only the
  // low 48 bits can carry significance.
  assign prod_full      = in_sum + in_carry;
  assign unused_prod_hi = ^prod_full[PROD_W-1:MEAN_W];

  assign s2_accept = !out_valid_reg || out_ready;
  assign in_ready  = !s1_valid_reg || s2_accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
    end else if (in_ready) begin
      s1_valid_reg <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_prod_reg <= '0;
      s1_sign_reg <= 1'b0;
      s1_exp_reg  <= '0;
      s1_zero_reg <= 1'b0;
      s1_inf_reg  <= 1'b0;
      s1_nan_reg  <= 1'b0;
    end else if (in_valid && in_ready) begin
      s1_prod_reg <= prod_full[MEAN_W-1:0];
      s1_sign_reg <= in_sign;
      s1_exp_reg  <= in_exp;
      s1_zero_reg <= in_zero;
      s1_inf_reg  <= in_inf;
      s1_nan_reg  <= in_nan;
    end
  end

  // Normalize and round. A product with both top bits clear is an upstream fault
  // and simply follows the unshifted path.
  always_comb begin
    norm_hi = s1_prod_reg[47];
    if (norm_hi) begin
      man_pre    = s1_prod_reg[46:24];
      guard_bit  = s1_prod_reg[23];
      sticky_bit = |s1_prod_reg[22:0];
    end else begin
      man_pre    = s1_prod_reg[45:23];
      guard_bit  = s1_prod_reg[22];
      sticky_bit = |s1_prod_reg[21:0];
    end
    round_up = guard_bit && (sticky_bit || man_pre[0]);
    man_sum  = {1'b0, man_pre} + {23'd0, round_up};
    // Mantissa wrap to 2^23 leaves man_sum[22:0] zero and bumps the exponent.
    e_rnd    = $signed({{2{s1_exp_reg[EXP_W-1]}}, s1_exp_reg})
             + $signed({{(E_W-1){1'b0}}, norm_hi})
             + $signed({{(E_W-1){1'b0}}, man_sum[23]});
  end

  always_comb begin
    result_next    = '0;
    overflow_next  = 1'b0;
    underflow_next = 1'b0;
    if (s1_nan_reg) begin
      result_next = 32'h7FC0_0000;
    end else if (s1_inf_reg) begin
      result_next = {s1_sign_reg, 8'hFF, 23'd0};
    end else if (s1_zero_reg) begin
      result_next = {s1_sign_reg, 31'd0};
    end else if (e_rnd >= E_MAX) begin
      result_next   = {s1_sign_reg, 8'hFF, 23'd0};
      overflow_next = 1'b1;
    end else if (e_rnd <= E_ZERO) begin
      result_next    = {s1_sign_reg, 31'd0};
      underflow_next = 1'b1;
    end else begin
      result_next = {s1_sign_reg, e_rnd[7:0], man_sum[22:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg     <= 1'b0;
      out_result_reg    <= '0;
      out_overflow_reg  <= 1'b0;
      out_underflow_reg <= 1'b0;
    end else if (s2_accept) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_result_reg    <= result_next;
        out_overflow_reg  <= overflow_next;
        out_underflow_reg <= underflow_next;
      end
    end
  end

  assign out_valid     = out_valid_reg;
  assign out_result    = out_result_reg;
  assign out_overflow  = out_overflow_reg;
  assign out_underflow = out_underflow_reg;

endmodule

// File: tb/tb_fp32_mul_round_normalize.sv
// Self-checking bench for fp32_mul_round_normalize: directed vector table, hand-written
// latency/backpressure/reset sequences, and random beats checked against an arithmetic model.
module tb_fp32_mul_round_normalize;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
  } exp_t;

  typedef struct {
    logic [51:0] sum;
    logic [51:0] carry;
    logic        sign;
    int          ex;
    logic        z;
    logic        i;
    logic        n;
    logic [31:0] res;
    logic        ovf;
    logic        unf;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [51:0] in_sum;
  logic [51:0] in_carry;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic        in_zero;
  logic        in_inf;
  logic        in_nan;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_underflow;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;
  exp_t sb[$];
  exp_t cur_exp;

  fp32_mul_round_normalize #(.PROD_W(52), .EXP_W(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sum       (in_sum),
    .in_carry     (in_carry),
    .in_sign      (in_sign),
    .in_exp       (in_exp),
    .in_zero      (in_zero),
    .in_inf       (in_inf),
    .in_nan       (in_nan),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_overflow (out_overflow),
    .out_underflow(out_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Value model: exact product is P * 2^(ex-127-46); round to 24 significant bits.
  function automatic exp_t ref_model(input logic [51:0] s, input logic [51:0] c,
                                     input logic sg, input int ex,
                                     input logic z, input logic i, input logic n);
    exp_t r;
    longint unsigned p, q, rem, half;
    int sh, e;
    r = '{res: 32'h0, ovf: 1'b0, unf: 1'b0};
    p = (64'(s) + 64'(c)) & 64'h0000_FFFF_FFFF_FFFF;
    if (n) r.res = 32'h7FC0_0000;
    else if (i) r.res = {sg, 8'hFF, 23'h0};
    else if (z) r.res = {sg, 31'h0};
    else begin
      sh   = p[47] ? 24 : 23;
      q    = p >> sh;
      rem  = p - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      e = ex + sh - 23;
      if (q >= (64'd1 << 24)) begin
        q = q >> 1;
        e++;
      end
      if (e >= 255) begin
        r.res = {sg, 8'hFF, 23'h0};
        r.ovf = 1'b1;
      end else if (e <= 0) begin
        r.res = {sg, 31'h0};
        r.unf = 1'b1;
      end else begin
        r.res = {sg, 8'(e), q[22:0]};
      end
    end
    return r;
  endfunction

  // Monitor: records accepted inputs, checks delivered outputs in order.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", out_result, 32'hxxxx_xxxx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_out++;
        $display("out #%0d result=%h ovf=%0b unf=%0b (exp %h %0b %0b)",
                 n_out, out_result, out_overflow, out_underflow, e.res, e.ovf, e.unf);
        check("result", out_result, e.res);
        check("flags", {30'd0, out_overflow, out_underflow}, {30'd0, e.ovf, e.unf});
      end
    end
    if (!rst && in_valid && in_ready) sb.push_back(cur_exp);
  end

  task automatic apply(input vec_t v);
    in_sum   = v.sum;
    in_carry = v.carry;
    in_sign  = v.sign;
    in_exp   = 10'(v.ex);
    in_zero  = v.z;
    in_inf   = v.i;
    in_nan   = v.n;
    cur_exp  = '{res: v.res, ovf: v.ovf, unf: v.unf};
    in_valid = 1'b1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is taken.
  task automatic send(input vec_t v);
    int cnt;
    cnt = 0;
    apply(v);
    forever begin
      @(negedge clk);
      if (in_ready) break;
      cnt++;
      if (cnt > 200) begin
        $display("FAIL send_timeout: in_ready low for %0d cycles", cnt);
        $fatal(1);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int cnt;
    cnt = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    while ((sb.size() != 0 || out_valid) && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("drain_timeout", 32'(cnt >= 100), 32'd0);
    @(posedge clk); #1;
  endtask

  vec_t tbl[14];
  vec_t v;
  exp_t m;
  logic [47:0] p48;
  logic [51:0] rs;
  int   ex;
  logic [31:0] held;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //          sum               carry             sg ex   z  i  n  res            ovf unf
    tbl[0]  = '{52'h900000000000, 52'h0,            0, 127, 0, 0, 0, 32'h40100000, 0, 0};
    tbl[1]  = '{52'hFFFFFFFFFFFFF, 52'h400000000001, 0, 127, 0, 0, 0, 32'h3F800000, 0, 0};
    tbl[2]  = '{52'h7FFFFFFFFFFF, 52'h0,            0, 127, 0, 0, 0, 32'h40000000, 0, 0};
    tbl[3]  = '{52'h400000400000, 52'h0,            0, 127, 0, 0, 0, 32'h3F800000, 0, 0};
    tbl[4]  = '{52'h400000C00000, 52'h0,            0, 127, 0, 0, 0, 32'h3F800002, 0, 0};
    tbl[5]  = '{52'h800000000000, 52'h0,            0, 254, 0, 0, 0, 32'h7F800000, 1, 0};
    tbl[6]  = '{52'h400000000000, 52'h0,            1, 0,   0, 0, 0, 32'h80000000, 0, 1};
    tbl[7]  = '{52'h900000000000, 52'h0,            1, 127, 0, 1, 1, 32'h7FC00000, 0, 0};
    tbl[8]  = '{52'h900000000000, 52'h0,            1, 127, 1, 1, 0, 32'hFF800000, 0, 0};
    tbl[9]  = '{52'h800000000000, 52'h0,            1, 254, 1, 0, 0, 32'h80000000, 0, 0};
    tbl[10] = '{52'h800000000000, 52'h0,            0, -5,  0, 0, 0, 32'h00000000, 0, 1};
    tbl[11] = '{52'hFFFFFFFFFFFF, 52'h0,            0, 253, 0, 0, 0, 32'h7F800000, 1, 0};
    tbl[12] = '{52'h7FFFFFFFFFFF, 52'h0,            0, 1,   0, 0, 0, 32'h01000000, 0, 0};
    tbl[13] = '{52'h3FFFFFC00000, 52'h0,            0, 127, 0, 0, 0, 32'h40000000, 0, 0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_sum = '0; in_carry = '0; in_sign = 1'b0; in_exp = '0;
    in_zero = 1'b0; in_inf = 1'b0; in_nan = 1'b0;
    cur_exp = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", out_result, 32'h0);
    check("rst_flags", {30'd0, out_overflow, out_underflow}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Latency: beat presented in cycle 0 shows on out_valid in cycle 2
    apply(tbl[0]);
    @(negedge clk);
    check("lat_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_cycle1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_cycle2_valid", 32'(out_valid), 32'd1);
    check("lat_cycle2_result", out_result, 32'h40100000);
    @(posedge clk); #1;
    drain();

    // Directed table, full throughput
    for (int k = 0; k < 14; k++) send(tbl[k]);
    drain();

    // Backpressure: three back-to-back beats with output stalled
    out_ready = 1'b0;
    apply(tbl[0]);
    @(negedge clk);
    check("bp_ready_1", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    apply(tbl[2]);
    @(negedge clk);
    check("bp_ready_2", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    apply(tbl[4]);
    @(negedge clk);
    check("bp_ready_drop", 32'(in_ready), 32'd0);
    held = out_result;
    check("bp_head_result", held, 32'h40100000);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_hold_result", out_result, held);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_drain_v1", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_drain_v2", 32'(out_valid), 32'd1);
    @(negedge clk);
    check("bp_drain_v3", 32'(out_valid), 32'd1);
    @(negedge clk);
    check("bp_drain_done", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    drain();

    // Random beats with random stalls, checked against the value model
    for (int k = 0; k < 300; k++) begin
      p48 = 48'({$urandom, $urandom});
      if ($urandom_range(0, 1) == 1) p48[47] = 1'b1;
      else p48[47:46] = 2'b01;
      case ($urandom_range(0, 5))
        0: p48[23:0] = 24'h400000;
        1: p48[23:0] = 24'hC00000;
        2: p48[22:0] = 23'h400000;
        3: p48[45:0] = '1;
        default: ;
      endcase
      rs = 52'({$urandom, $urandom});
      ex = int'($urandom_range(0, 300)) - 20;
      v.sum   = rs;
      v.carry = 52'(p48) - rs;
      v.sign  = 1'($urandom_range(0, 1));
      v.ex    = ex;
      v.z     = ($urandom_range(0, 19) == 0);
      v.i     = ($urandom_range(0, 19) == 0);
      v.n     = ($urandom_range(0, 19) == 0);
      m = ref_model(v.sum, v.carry, v.sign, v.ex, v.z, v.i, v.n);
      v.res = m.res; v.ovf = m.ovf; v.unf = m.unf;
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
      send(v);
    end
    drain();

    // Reset with both stages full: nothing stale may emerge
    out_ready = 1'b0;
    apply(tbl[2]);
    @(posedge clk); #1;
    apply(tbl[3]);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("full_out_valid", 32'(out_valid), 32'd1);
    check("full_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("midrst_no_stale", 32'(out_valid), 32'd0);
    end
    check("midrst_sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp32_mul_round_normalize.md
Name: fp32_mul_round_normalize

Overview:
- Final stage of the FP32 multiplier datapath; sits directly downstream of the 13-row Wallace-tree compressor.
- Consumes the 52-bit redundant sum/carry pair plus exponent/sign sideband from the upstream stage.
- Performs the carry-propagate add, normalization and IEEE-754 round-to-nearest-even, then emits a packed FP32 result with status flags.
- Two-stage valid/ready pipeline; denormals are flushed to zero.

Parameters:
- PROD_W, 52, width of the redundant sum/carry inputs.
- EXP_W, 10, width of the signed pre-normalization exponent input.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_sum  in  PROD_W  compressor sum vector.
- in_carry  in  PROD_W  compressor carry vector, already aligned; added as-is.
- in_sign  in  1  product sign (sa ^ sb).
- in_exp  in  EXP_W  signed two's-complement exponent, ea + eb - 127.
- in_zero  in  1  an operand is zero.
- in_inf  in  1  an operand is infinite.
- in_nan  in  1  result is NaN (NaN operand, or inf*0).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_result  out  32  packed FP32 result.
- out_overflow  out  1  result saturated to infinity.
- out_underflow  out  1  result flushed to zero.

Behaviour:
- Reset: out_valid=0, out_result=0, out_overflow=0, out_underflow=0, both stage valids=0. Reset discards any in-flight beats. in_ready=1 in the cycle after rst deasserts.
- Handshake:
  - A beat transfers on in_valid & in_ready; the output transfers on out_valid & out_ready.
  - in_ready = !s1_valid | s2_accept, where s2_accept = !out_valid | out_ready. The combinational ready chain is allowed.
  - While out_valid & !out_ready, out_* hold stable.
  - Order is preserved; no beat is dropped or duplicated.
  - Capacity is 2 beats.
  - Latency is 2 cycles from input transfer to out_valid with out_ready held high. Throughput is 1 beat per cycle.
- S1 (registered on transfer):
  - P = (in_sum + in_carry) mod 2^52; only P[47:0] is meaningful.
  - Sideband is registered alongside P.
- S2 normalize (registered when s2_accept):
  - If P[47]=1: man=P[46:24], g=P[23], st=|P[22:0], e=in_exp+1.
  - Else: man=P[45:23], g=P[22], st=|P[21:0], e=in_exp.
- S2 round (RNE):
  - Round up when g & (st | man[0]).
  - If man overflows to 2^23, set man=0 and e=e+1.
- Exponent check (evaluated after rounding):
  - e >= 255: out_result = {sign, 8'hFF, 23'b0}, out_overflow=1.
  - e <= 0: out_result = {sign, 31'b0}, out_underflow=1.
  - Otherwise: {sign, e[7:0], man}.
- Special-case priority: nan > inf > zero > normal.
  - nan gives 32'h7FC00000.
  - inf gives {sign, 8'hFF, 23'b0}.
  - zero gives {sign, 31'b0}.
  - No flags are set for special results.
- P[47:46] = 00 with no special flag set indicates an upstream error. It must be handled as the P[47]=0 path; no assertion is raised in RTL.

Test Plan:
- 1.5*1.5: in_sum=52'h900000000000, in_carry=0, in_exp=127, sign=0 -> out_result=32'h40100000 two cycles after transfer, no flags.
- 1.0*1.0 with redundant split: in_sum=52'hFFFFFFFFFFFFF, in_carry=52'h400000000001, in_exp=127 -> 32'h3F800000 (checks the mod-2^52 add).
- Rounding:
  - P=52'h7FFFFFFFFFFF, exp 127 -> mantissa overflow -> 32'h40000000.
  - P=52'h400000400000 (tie, lsb 0) -> 32'h3F800000.
  - P=52'h400000C00000 (tie, lsb 1) -> 32'h3F800002.
- Range:
  - P[47]=1, in_exp=254 -> 32'h7F800000 with out_overflow=1.
  - P=52'h400000000000, in_exp=0, sign=1 -> 32'h80000000 with out_underflow=1.
  - in_nan=1 -> 32'h7FC00000.
- Backpressure: out_ready=0, send 3 back-to-back beats. in_ready must drop after 2 accepted. Outputs stay stable while stalled. Raising out_ready drains all 3 in order, 1 per cycle.
- Reset mid-stream: assert rst for 1 cycle with both stages full -> next cycle out_valid=0, and no stale beat emerges afterward.
